rx_module: RTL and testbench
============================

RX_MODULE -- requirements
Module: rx_module

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_W, default 8: maximum UART data width.
REQ-002 SHALL have parameter STOP_CONF_W, default 2: stop-bit config field width.
REQ-003 SHALL have parameter DATA_CONF_W, default 2: data-bit config field width.
REQ-004 SHALL have parameter SAMPLE_COUNT_W, default 4: oversample counter width (16 samples/bit).
REQ-005 SHALL have parameter DATA_COUNTER_W, default 3: data bit counter width.
REQ-006 SHALL have parameter TOTAL_CONF_W, default STOP_CONF_W+DATA_CONF_W+1: config bus width.
REQ-007 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port baud_en_i  input  1  16x-baud sample tick, one clk wide.
REQ-010 SHALL have port rx_en_i  input  1  receiver enable.
REQ-011 SHALL have port rx_conf_i  input  TOTAL_CONF_W  {data[1:0], stop[1:0], parity_en}.
REQ-012 SHALL have port rx_fifo_en_i  input  1  enables rx_fifo_push_o.
REQ-013 SHALL have port uart_rx_i  input  1  external UART line, asynchronous, idle high.
REQ-014 SHALL have port rx_data_o  output  MAX_UART_DATA_W  last received character, right-aligned.
REQ-015 SHALL have port rx_done_o  output  1  one-clk pulse per completed character.
REQ-016 SHALL have port rx_busy_o  output  1  high from valid start detection to Done.
REQ-017 SHALL have port parity_err_o  output  1  parity error of last character.
REQ-018 SHALL have port frame_err_o  output  1  stop-bit error of last character.
REQ-019 SHALL have port rx_fifo_push_o  output  1  one-clk push strobe to Rx FIFO.

Function
REQ-020 SHALL pass uart_rx_i through a 2-flop synchronizer (reset value 1) before any use.
REQ-021 SHALL implement states Reset, Idle, RecvStart, RecvData, RecvParity, RecvStop, Done; state updates only on clk cycles with baud_en_i=1.
REQ-022 SHALL transition Reset->Idle when rx_en_i=1; Done->Idle if rx_en_i=1, else Done->Reset.
REQ-023 SHALL transition Idle->RecvStart on a baud tick with synchronized line=0, clearing sample counter and latching rx_conf_i.
REQ-024 SHALL, in RecvStart at sample count 7, return to Idle (false start, no done, busy cleared) if line=1; else continue to RecvData at count 15.
REQ-025 SHALL count samples 0..15 per bit in all Recv states, wrapping 15->0; bit decision at count 8, state advance at count 15.
REQ-026 SHALL receive 5+data[1:0] data bits LSB first into bit index data_counter; unused upper bits of rx_data_o SHALL read 0.
REQ-027 SHALL enter RecvParity after last data bit if parity_en=1, else RecvStop.
REQ-028 SHALL flag parity error when received parity bit != XOR of received data bits (even parity).
REQ-029 SHALL receive stop[1:0]+1 stop bits; any stop bit sampled 0 sets frame error; reception still completes to Done.
REQ-030 SHALL update rx_data_o, parity_err_o, frame_err_o together on Done entry and hold them until next Done entry.
REQ-031 SHALL pulse rx_done_o for exactly one clk on Done entry; rx_fifo_push_o same cycle only if rx_fifo_en_i=1.
REQ-032 SHALL ignore rx_conf_i changes mid-character; latched config used until next start.
REQ-033 SHALL send illegal state encodings to Reset.

Reset
REQ-034 SHALL, on rst_i=1 at any time incl. mid-frame, immediately force state Reset, all counters 0, synchronizer 1, and all outputs 0.

Configuration
REQ-035 SHALL, with macro RX_MAJORITY_VOTE_EN defined, decide each bit (incl. start check at 7/8/9) as majority of samples at counts 7, 8, 9.
REQ-036 SHALL, without RX_MAJORITY_VOTE_EN, use single sample at count 8 (start check at count 7).

Verification
REQ-037 SHALL cover 8N1 (conf 5'b11000), byte 0xA5 -> rx_data_o=0xA5, one rx_done_o, both errors 0.
REQ-038 SHALL cover 5-bit, parity, 2 stop (conf 5'b00011), 0x13 parity 1 -> 0x13, parity_err_o=0; parity bit 0 -> parity_err_o=1.
REQ-039 SHALL cover line low for 4 ticks then high -> return to Idle, no rx_done_o, rx_busy_o=0.
REQ-040 SHALL cover 8N1 byte 0x3C with stop bit 0 -> rx_data_o=0x3C, frame_err_o=1, rx_done_o pulsed.
REQ-041 SHALL cover rst_i asserted mid data bit 3 -> outputs 0 without clock edge; next frame 0x5A received correctly.
REQ-042 SHALL cover, with RX_MAJORITY_VOTE_EN, a 1-tick glitch at count 8 of a data bit -> bit unchanged; without macro -> bit flipped.

Source files
------------

// File: rtl/rx_module.sv
// UART receiver: 16x oversampled, configurable data/stop/parity, registered status outputs.
// Define RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote over samples 7, 8 and 9.
module rx_module #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int SAMPLE_COUNT_W  = 4,
    parameter int DATA_COUNTER_W  = 3,
    parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       baud_en_i,
    input  logic                       rx_en_i,
    input  logic [TOTAL_CONF_W-1:0]    rx_conf_i,
    input  logic                       rx_fifo_en_i,
    input  logic                       uart_rx_i,
    output logic [MAX_UART_DATA_W-1:0] rx_data_o,
    output logic                       rx_done_o,
    output logic                       rx_busy_o,
    output logic                       parity_err_o,
    output logic                       frame_err_o,
    output logic                       rx_fifo_push_o
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [SAMPLE_COUNT_W-1:0] LAST_CNT = {SAMPLE_COUNT_W{1'b1}};
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [SAMPLE_COUNT_W-1:0] DEC_CNT   = SAMPLE_COUNT_W'(9);
    localparam logic [SAMPLE_COUNT_W-1:0] START_CNT = SAMPLE_COUNT_W'(9);
`else
    localparam logic [SAMPLE_COUNT_W-1:0] DEC_CNT   = SAMPLE_COUNT_W'(8);
    localparam logic [SAMPLE_COUNT_W-1:0] START_CNT = SAMPLE_COUNT_W'(7);
`endif

    logic                       sync1_q, sync2_q;
    state_t                     state_q, state_d;
    logic [SAMPLE_COUNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [DATA_COUNTER_W-1:0]  data_cnt_q, data_cnt_d;
    logic [TOTAL_CONF_W-1:0]    conf_q, conf_d;
    logic [MAX_UART_DATA_W-1:0] shift_q, shift_d;
    logic                       par_bit_q, par_bit_d;
    logic                       ferr_acc_q, ferr_acc_d;
    logic [MAX_UART_DATA_W-1:0] rx_data_q, rx_data_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       push_q, push_d;
`ifdef RX_MAJORITY_VOTE_EN
    logic                       s7_q, s7_d, s8_q, s8_d;
`endif

    logic                       line;
    logic                       bit_val;
    logic [DATA_COUNTER_W-1:0]  last_data_idx;
    logic [DATA_COUNTER_W-1:0]  last_stop_idx;

    assign line          = sync2_q;
    assign last_data_idx = DATA_COUNTER_W'(conf_q[TOTAL_CONF_W-1 -: DATA_CONF_W]) + DATA_COUNTER_W'(4);
    assign last_stop_idx = DATA_COUNTER_W'(conf_q[STOP_CONF_W:1]);

`ifdef RX_MAJORITY_VOTE_EN
    assign bit_val = (s7_q & s8_q) | (s7_q & line) | (s8_q & line);
`else
    assign bit_val = line;
`endif

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        data_cnt_d   = data_cnt_q;
        conf_d       = conf_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        ferr_acc_d   = ferr_acc_q;
        rx_data_d    = rx_data_q;
        busy_d       = busy_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        done_d       = 1'b0;
        push_d       = 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
        s7_d         = s7_q;
        s8_d         = s8_q;
`endif
        if (baud_en_i) begin
`ifdef RX_MAJORITY_VOTE_EN
            if (sample_cnt_q == SAMPLE_COUNT_W'(7)) s7_d = line;
            if (sample_cnt_q == SAMPLE_COUNT_W'(8)) s8_d = line;
`endif
            if (state_q == S_START || state_q == S_DATA ||
                state_q == S_PARITY || state_q == S_STOP)
                sample_cnt_d = sample_cnt_q + 1'b1;

            case (state_q)
                S_RESET: if (rx_en_i) state_d = S_IDLE;
                S_IDLE: begin
                    if (!line) begin
                        state_d      = S_START;
                        sample_cnt_d = '0;
                        data_cnt_d   = '0;
                        conf_d       = rx_conf_i;
                        shift_d      = '0;
                        ferr_acc_d   = 1'b0;
                        busy_d       = 1'b1;
                    end
                end
                S_START: begin
                    // Line back high mid start bit: glitch, not a character.
                    if (sample_cnt_q == START_CNT && bit_val) begin
                        state_d      = S_IDLE;
                        sample_cnt_d = '0;
                        busy_d       = 1'b0;
                    end else if (sample_cnt_q == LAST_CNT) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (sample_cnt_q == DEC_CNT) shift_d[data_cnt_q] = bit_val;
                    if (sample_cnt_q == LAST_CNT) begin
                        if (data_cnt_q == last_data_idx) begin
                            data_cnt_d = '0;
                            state_d    = conf_q[0] ? S_PARITY : S_STOP;
                        end else begin
                            data_cnt_d = data_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_cnt_q == DEC_CNT) par_bit_d = bit_val;
                    if (sample_cnt_q == LAST_CNT) state_d = S_STOP;
                end
                S_STOP: begin
                    if (sample_cnt_q == DEC_CNT && !bit_val) ferr_acc_d = 1'b1;
                    if (sample_cnt_q == LAST_CNT) begin
                        if (data_cnt_q == last_stop_idx) begin
                            state_d   = S_DONE;
                            rx_data_d = shift_q;
                            perr_d    = conf_q[0] & (par_bit_q ^ (^shift_q));
                            ferr_d    = ferr_acc_q;
                            done_d    = 1'b1;
                            push_d    = rx_fifo_en_i;
                            busy_d    = 1'b0;
                        end else begin
                            data_cnt_d = data_cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_d      = rx_en_i ? S_IDLE : S_RESET;
                    sample_cnt_d = '0;
                    data_cnt_d   = '0;
                end
                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_RESET;
            sample_cnt_q <= '0;
            data_cnt_q   <= '0;
            conf_q       <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            push_q       <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
`endif
        end else begin
            sync1_q      <= uart_rx_i;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            data_cnt_q   <= data_cnt_d;
            conf_q       <= conf_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            ferr_acc_q   <= ferr_acc_d;
            rx_data_q    <= rx_data_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            push_q       <= push_d;
`ifdef RX_MAJORITY_VOTE_EN
            s7_q         <= s7_d;
            s8_q         <= s8_d;
`endif
        end
    end

    assign rx_data_o      = rx_data_q;
    assign rx_done_o      = done_q;
    assign rx_busy_o      = busy_q;
    assign parity_err_o   = perr_q;
    assign frame_err_o    = ferr_q;
    assign rx_fifo_push_o = push_q;

endmodule

// File: tb/tb_rx_module.sv
// Scoreboard bench for rx_module: directed UART frames, expected characters queued, monitor checks on rx_done_o.
module tb_rx_module;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic       rx_en = 1'b0;
    logic [4:0] rx_conf = 5'b11000;
    logic       fifo_en = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, rx_busy, perr, ferr, push;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       push;
    } exp_t;
    exp_t sb[$];

    rx_module dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .baud_en_i     (baud_en),
        .rx_en_i       (rx_en),
        .rx_conf_i     (rx_conf),
        .rx_fifo_en_i  (fifo_en),
        .uart_rx_i     (uart_rx),
        .rx_data_o     (rx_data),
        .rx_done_o     (rx_done),
        .rx_busy_o     (rx_busy),
        .parity_err_o  (perr),
        .frame_err_o   (ferr),
        .rx_fifo_push_o(push)
    );

    always #5 clk = ~clk;

    // 16x tick: one clk high out of every four
    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n = n + 1;
            baud_en = (n % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_done) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_done actual=%0h expected=none at %0t", rx_data, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                chk("parity_err", {31'd0, perr}, {31'd0, e.pe});
                chk("frame_err", {31'd0, ferr}, {31'd0, e.fe});
                chk("fifo_push", {31'd0, push}, {31'd0, e.push});
            end
        end
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!baud_en) @(posedge clk);
        #1;
    endtask

    // gpos: tick index within the bit that is inverted (-1 none); index 9 lands on sample count 8
    task automatic send_bit(input logic v, input int gpos);
        for (int j = 0; j < 16; j++) begin
            uart_rx = (j == gpos) ? ~v : v;
            wait_tick();
        end
        uart_rx = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input logic par_bit, input int nstop, input logic stop_v,
                              input int gbit, input bit conf_mid, input logic [4:0] mid_conf);
        send_bit(1'b0, -1);
        if (conf_mid) rx_conf = mid_conf;
        for (int i = 0; i < nbits; i++) send_bit(d[i], (i == gbit) ? 9 : -1);
        if (par_en) send_bit(par_bit, -1);
        for (int s = 0; s < nstop; s++) send_bit(stop_v, -1);
        uart_rx = 1'b1;
        repeat (4) wait_tick();
    endtask

    task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe, input logic p);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.push = p;
        sb.push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_done", {31'd0, rx_done}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_perr", {31'd0, perr}, 32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_push", {31'd0, push}, 32'd0);
        rst = 1'b0;
        rx_en = 1'b1;
        repeat (4) wait_tick();

        // 8N1 0xA5
        rx_conf = 5'b11000; fifo_en = 1'b1;
        expect_char(8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0, 5'b0);

        // 5 bits, even parity, 2 stop: 0x13 -> data bits 1,1,0,0,1 xor = 1
        rx_conf = 5'b00011;
        expect_char(8'h13, 1'b0, 1'b0, 1'b1);
        send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b1, -1, 1'b0, 5'b0);

        // wrong parity bit, fifo push disabled, config changed mid-character
        fifo_en = 1'b0;
        expect_char(8'h13, 1'b1, 1'b0, 1'b0);
        send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b1, -1, 1'b1, 5'b11000);

        // false start: low for 4 ticks
        rx_conf = 5'b11000; fifo_en = 1'b1;
        uart_rx = 1'b0;
        repeat (4) wait_tick();
        chk("false_start_busy_hi", {31'd0, rx_busy}, 32'd1);
        uart_rx = 1'b1;
        repeat (24) wait_tick();
        chk("false_start_busy_lo", {31'd0, rx_busy}, 32'd0);

        // 8N1 0x3C with stop bit 0
        expect_char(8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0, 5'b0);

        // async reset during data bit 3 of 0x5A
        send_bit(1'b0, -1);
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        uart_rx = 1'b1;
        repeat (5) wait_tick();
        chk("mid_busy", {31'd0, rx_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("mid_rst_ferr", {31'd0, ferr}, 32'd0);
        chk("mid_rst_perr", {31'd0, perr}, 32'd0);
        chk("mid_rst_done", {31'd0, rx_done}, 32'd0);
        chk("mid_rst_push", {31'd0, push}, 32'd0);
        #40 rst = 1'b0;
        repeat (4) wait_tick();
        expect_char(8'h5A, 1'b0, 1'b0, 1'b1);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0, 5'b0);

        // one-tick glitch at sample 8 of data bit 3 of 0x81
`ifdef RX_MAJORITY_VOTE_EN
        expect_char(8'h81, 1'b0, 1'b0, 1'b1);
`else
        expect_char(8'h89, 1'b0, 1'b0, 1'b1);
`endif
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 3, 1'b0, 5'b0);

        repeat (10) wait_tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
